// File: rtl/mimo_backsub_detector_if.sv
// Handshake and data bus of the MIMO back-substitution detector.
interface mimo_backsub_detector_if #(
  parameter int N = 4,
  parameter int W = 28
);
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   z_re;
  logic [N*W-1:0]   z_im;
  logic [N*N*W-1:0] r_re;
  logic [N*N*W-1:0] r_im;
  logic [N*W-1:0]   rinv;
  logic             qam16;
  logic             out_valid;
  logic             out_ready;
  logic [N*3-1:0]   demod_re;
  logic [N*3-1:0]   demod_im;
  logic [N*W-1:0]   x_re;
  logic [N*W-1:0]   x_im;

  modport master (
    output in_valid, z_re, z_im, r_re, r_im, rinv, qam16, out_ready,
    input  in_ready, out_valid, demod_re, demod_im, x_re, x_im
  );

  modport slave (
    input  in_valid, z_re, z_im, r_re, r_im, rinv, qam16, out_ready,
    output in_ready, out_valid, demod_re, demod_im, x_re, x_im
  );
endinterface

// File: rtl/mimo_backsub_detector.sv
// Sequential back-substitution MIMO detector (R*x = z) with QPSK/16QAM slicing.
// Define MIMO_SOFT_OUT_EN to expose the soft estimates x on x_re/x_im while in DONE.
module mimo_backsub_detector #(
  parameter int N    = 4,
  parameter int W    = 28,
  parameter int FRAC = 16
) (
  input logic                    clk,
  input logic                    rst,
  mimo_backsub_detector_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam int AW = W + 4;
  localparam int PW = 2 * W + 1;
  localparam int SW = AW + W;

  localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - SW'(1);
  localparam logic signed [W-1:0]  TWO_ONE = W'(64'sd2 <<< FRAC);
  localparam logic signed [W-1:0]  NEG_TWO_ONE = -TWO_ONE;

  typedef enum logic [2:0] {IDLE, MAC, SCALE, SLICE, DONE} state_t;

  state_t state_q, state_d;

  logic signed [W-1:0]  z_re_q [N];
  logic signed [W-1:0]  z_im_q [N];
  logic signed [W-1:0]  rinv_q [N];
  logic signed [W-1:0]  r_re_q [N][N];
  logic signed [W-1:0]  r_im_q [N][N];
  logic signed [W-1:0]  x_re_q [N];
  logic signed [W-1:0]  x_im_q [N];
  logic signed [2:0]    dm_re_q [N];
  logic signed [2:0]    dm_im_q [N];
  logic                 qam_q;
  logic signed [AW-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;
  logic [CW-1:0]        row_q, col_q;
  logic                 accept;

  logic signed [PW-1:0] prod_re, prod_im;
  logic signed [SW-1:0] sc_re, sc_im;

  function automatic logic signed [W-1:0] sat_w(input logic signed [SW-1:0] v);
    if (v > SAT_MAX) return W'(SAT_MAX);
    if (v < SAT_MIN) return W'(SAT_MIN);
    return W'(v);
  endfunction

  function automatic logic signed [2:0] slice(input logic signed [W-1:0] v, input logic qam);
    if (!v[W-1]) return (qam && (v >= TWO_ONE)) ? 3'sd3 : 3'sd1;
    return (qam && (v <= NEG_TWO_ONE)) ? -3'sd3 : -3'sd1;
  endfunction

  assign accept = bus.in_valid && (state_q == IDLE);

  // Complex R(row,col)*x[col] for MAC and real rinv scaling for SCALE.
  always_comb begin
    prod_re = PW'(r_re_q[row_q][col_q]) * PW'(x_re_q[col_q])
            - PW'(r_im_q[row_q][col_q]) * PW'(x_im_q[col_q]);
    prod_im = PW'(r_re_q[row_q][col_q]) * PW'(x_im_q[col_q])
            + PW'(r_im_q[row_q][col_q]) * PW'(x_re_q[col_q]);
    sc_re   = SW'(acc_re_q) * SW'(rinv_q[row_q]);
    sc_im   = SW'(acc_im_q) * SW'(rinv_q[row_q]);
  end

  always_comb begin
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    unique case (state_q)
      IDLE: if (accept) begin
        acc_re_d = AW'($signed(bus.z_re[(N-1)*W +: W]));
        acc_im_d = AW'($signed(bus.z_im[(N-1)*W +: W]));
      end
      MAC: begin
        acc_re_d = acc_re_q - AW'(prod_re >>> FRAC);
        acc_im_d = acc_im_q - AW'(prod_im >>> FRAC);
      end
      SCALE: if (row_q != '0) begin
        acc_re_d = AW'(z_re_q[row_q - 1'b1]);
        acc_im_d = AW'(z_im_q[row_q - 1'b1]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = SCALE;
      MAC:     if (col_q == CW'(N - 1)) state_d = SCALE;
      SCALE:   state_d = (row_q == '0) ? SLICE : MAC;
      SLICE:   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.demod_re  = '0;
    bus.demod_im  = '0;
    bus.x_re      = '0;
    bus.x_im      = '0;
    for (int i = 0; i < N; i++) begin
      bus.demod_re[i*3 +: 3] = dm_re_q[i];
      bus.demod_im[i*3 +: 3] = dm_im_q[i];
`ifdef MIMO_SOFT_OUT_EN
      if (state_q == DONE) begin
        bus.x_re[i*W +: W] = x_re_q[i];
        bus.x_im[i*W +: W] = x_im_q[i];
      end
`endif
    end
  end

  // Control: accumulator, row/col indices and decisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_re_q <= '0;
      acc_im_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      for (int i = 0; i < N; i++) begin
        dm_re_q[i] <= '0;
        dm_im_q[i] <= '0;
      end
    end else begin
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      unique case (state_q)
        IDLE:  if (accept) row_q <= CW'(N - 1);
        MAC:   col_q <= col_q + 1'b1;
        SCALE: if (row_q != '0) begin
          row_q <= row_q - 1'b1;
          col_q <= row_q;
        end
        SLICE: for (int i = 0; i < N; i++) begin
          dm_re_q[i] <= slice(x_re_q[i], qam_q);
          dm_im_q[i] <= slice(x_im_q[i], qam_q);
        end
        default: ;
      endcase
    end
  end

  // Data: job operands captured at accept, soft estimates written in SCALE.
  always_ff @(posedge clk) begin
    if (accept) begin
      qam_q <= bus.qam16;
      for (int i = 0; i < N; i++) begin
        z_re_q[i] <= $signed(bus.z_re[i*W +: W]);
        z_im_q[i] <= $signed(bus.z_im[i*W +: W]);
        rinv_q[i] <= $signed(bus.rinv[i*W +: W]);
        for (int j = 0; j < N; j++) begin
          r_re_q[i][j] <= $signed(bus.r_re[(i*N+j)*W +: W]);
          r_im_q[i][j] <= $signed(bus.r_im[(i*N+j)*W +: W]);
        end
      end
    end
    if (state_q == SCALE) begin
      x_re_q[row_q] <= sat_w(sc_re >>> FRAC);
      x_im_q[row_q] <= sat_w(sc_im >>> FRAC);
    end
  end
endmodule

// File: doc/mimo_backsub_detector.md
MIMO_BACKSUB_DETECTOR -- requirements
Module: mimo_backsub_detector

Interface
REQ-001 Parameter N, default 4, antenna count (2..8).
REQ-002 Parameter W, default 28, signed component width of z, R, rinv and x.
REQ-003 Parameter FRAC, default 16, fractional bits; ONE = 2^FRAC.
REQ-004 Port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Ports in_valid (input, 1) and in_ready (output, 1), input handshake.
REQ-007 Ports z_re and z_im, input, N*W each, rotated receive vector (Q^H*y); element i at bits [i*W +: W].
REQ-008 Ports r_re and r_im, input, N*N*W each, upper-triangular R; element (i,j) at bits [(i*N+j)*W +: W]; entries with j<i are ignored.
REQ-009 Port rinv, input, N*W, real reciprocal 1/R(i,i) in Q(FRAC) format; element i at bits [i*W +: W].
REQ-010 Port qam16, input, 1; 1 selects 16QAM, 0 selects QPSK; sampled only on input accept.
REQ-011 Ports out_valid (output, 1) and out_ready (input, 1), output handshake.
REQ-012 Ports demod_re and demod_im, output, N*3 each, signed hard decision per antenna; antenna i at bits [i*3 +: 3].
REQ-013 Ports x_re and x_im, output, N*W each, soft estimates; antenna i at bits [i*W +: W].

Function
REQ-014 Input accept occurs on a rising edge where in_valid and in_ready are both 1; all inputs are registered at accept.
REQ-015 in_ready is 1 only in state IDLE; in_valid in any other state is ignored.
REQ-016 FSM states are IDLE, MAC, SCALE, SLICE and DONE.
REQ-017 On accept: row <= N-1, acc <= z[N-1], next state SCALE.
REQ-018 In MAC: acc <= acc - ((R(row,col)*x[col]) >>> FRAC) using a full complex product; col <= col+1; when col == N-1, next state is SCALE.
REQ-019 In SCALE: x[row] <= sat_W((acc*rinv[row]) >>> FRAC), applied separately to the real and imaginary parts.
REQ-020 From SCALE with row == 0, next state is SLICE.
REQ-021 From SCALE with row > 0: row <= row-1, col <= row, acc <= z[row-1], next state MAC.
REQ-022 acc width is W+4 bits; arithmetic shifts are used throughout; sat_W clamps to [-2^(W-1), 2^(W-1)-1].
REQ-023 Per-axis slicer for QPSK: v >= 0 gives +1, otherwise -1.
REQ-024 Per-axis slicer for 16QAM: sign as in QPSK; magnitude is 3 if |v| >= 2*ONE, otherwise 1.
REQ-025 SLICE computes all decisions in one cycle; next state is DONE.
REQ-026 out_valid is 1 only in DONE.
REQ-027 Latency: out_valid rises N(N+1)/2+1 clocks after the accept edge (11 clocks for N=4).
REQ-028 In DONE, demod_*, x_* and out_valid hold stable until out_ready is 1.
REQ-029 When out_valid and out_ready are both 1, the next state is IDLE; no accept occurs in that same cycle.
REQ-030 rinv[i] = 0 yields x[i] = 0 with no error indication.

Reset
REQ-031 rst has priority over all other activity, including mid-computation; the next state is IDLE.
REQ-032 rst forces in_ready=1, out_valid=0, demod_*=0, x_*=0, acc=0 and row=col=0; any in-flight job is discarded.

Configuration
REQ-033 With macro MIMO_SOFT_OUT_EN defined, x_re and x_im are driven with the x registers in DONE and are 0 in all other states.
REQ-034 Without MIMO_SOFT_OUT_EN, x_re and x_im are constant 0; demod behaviour and latency are unchanged.

Verification
REQ-035 N=4, R=I, rinv=ONE for all i, z_re={3,-1,1,-3}*ONE, z_im={1,1,-1,-1}*ONE, qam16=1 -> demod_re={3,-1,1,-3}, demod_im={1,1,-1,-1}; out_valid 11 clocks after accept.
REQ-036 N=4, R(0,1)=ONE (all other off-diagonal entries 0), R=I otherwise, z0=2*ONE, z1=ONE, qam16=0 -> x0=ONE and demod_re[0]=+1.
REQ-037 out_ready held 0 for 20 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE on the next cycle.
REQ-038 rst asserted in the 5th MAC/SCALE cycle -> next cycle IDLE with all outputs 0; a new job then completes with the normal 11-cycle latency.
REQ-039 Saturation and ties: rinv=ONE with z0 = 2^(W-1)-1 scaled by 4 via R -> x saturates to 2^(W-1)-1; v = 0 -> +1; v = -2*ONE -> -3 in 16QAM.
